// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory initiator on a req/gnt/rvalid port.
// Word-crossing accesses go out as two aligned beats and are merged back.
module load_store_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE
  } state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        split_q;
  logic [29:0] wa_q;
  logic [63:0] w64_q;
  logic [7:0]  m8_q;
  logic [31:0] lo_q;

  logic [2:0]  req_size;
  logic [31:0] req_wsz;
  logic        req_legal;
  logic        req_split;
  logic        req_bad;
  logic [7:0]  req_m8_raw;
  logic [7:0]  req_m8;
  logic [63:0] req_w64;

  logic [31:0] lo_v;
  logic [31:0] hi_v;
  logic [31:0] ld_sh;
  logic [31:0] ld_data;
  logic [31:0] b1_addr;

  // Decode size, legality, byte mask and lane data of the incoming request
  always_comb begin
    req_size = 3'd1;
    req_wsz  = {24'b0, req_wdata[7:0]};
    unique case (1'b1)
      (req_func3[1:0] == 2'b01): begin
        req_size = 3'd2;
        req_wsz  = {16'b0, req_wdata[15:0]};
      end
      (req_func3[1:0] == 2'b10): begin
        req_size = 3'd4;
        req_wsz  = req_wdata;
      end
      default: ;
    endcase
    if (req_we)
      req_legal = req_func3 inside {3'b000, 3'b001, 3'b010};
    else
      req_legal = req_func3 inside
        {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    req_split  = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;
    req_bad    = !req_legal || (!ALLOW_MISALIGNED && req_split);
    req_m8_raw = (8'd1 << req_size) - 8'd1;
    req_m8     = req_m8_raw << req_addr[1:0];
    req_w64    = {32'b0, req_wsz} << {req_addr[1:0], 3'b000};
  end

  // Merge the two read beats, shift down by the offset, then extend
  always_comb begin
    lo_v    = (state == WAIT0) ? mem_rdata : lo_q;
    hi_v    = (state == WAIT1) ? mem_rdata : 32'b0;
    ld_sh   = 32'({hi_v, lo_v} >> {off_q, 3'b000});
    ld_data = ld_sh;
    unique case (1'b1)
      (f3_q == 3'b000): ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
      (f3_q == 3'b001): ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
      (f3_q == 3'b100): ld_data = {24'b0, ld_sh[7:0]};
      (f3_q == 3'b101): ld_data = {16'b0, ld_sh[15:0]};
      default: ;
    endcase
    b1_addr = {wa_q + 30'd1, 2'b00};
  end

  // Transaction FSM; every port output is a register updated here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'b0;
      mem_wmask  <= 4'b0;
      mem_wdata  <= 32'b0;
      we_q       <= 1'b0;
      f3_q       <= 3'b0;
      off_q      <= 2'b0;
      split_q    <= 1'b0;
      wa_q       <= 30'b0;
      w64_q      <= 64'b0;
      m8_q       <= 8'b0;
      lo_q       <= 32'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            f3_q      <= req_func3;
            off_q     <= req_addr[1:0];
            split_q   <= req_split;
            wa_q      <= req_addr[31:2];
            w64_q     <= req_w64;
            m8_q      <= req_m8;
            if (req_bad) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'b0;
            end else begin
              state     <= ISSUE0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wmask <= req_we ? req_m8[3:0] : 4'b0;
              mem_wdata <= req_we ? req_w64[31:0] : 32'b0;
            end
          end
        end
        ISSUE0: begin
          if (mem_gnt) begin
            if (we_q && split_q) begin
              state     <= ISSUE1;
              mem_addr  <= b1_addr;
              mem_wmask <= m8_q[7:4];
              mem_wdata <= w64_q[63:32];
            end else begin
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= 32'b0;
              mem_wmask <= 4'b0;
              mem_wdata <= 32'b0;
              if (!we_q) begin
                state <= WAIT0;
              end else begin
                state      <= DONE;
                resp_valid <= 1'b1;
                resp_err   <= 1'b0;
                resp_rdata <= 32'b0;
              end
            end
          end
        end
        WAIT0: begin
          if (mem_rvalid) begin
            lo_q <= mem_rdata;
            if (split_q) begin
              state     <= ISSUE1;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= b1_addr;
              mem_wmask <= 4'b0;
              mem_wdata <= 32'b0;
            end else begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= ld_data;
            end
          end
        end
        ISSUE1: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'b0;
            mem_wmask <= 4'b0;
            mem_wdata <= 32'b0;
            if (we_q) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= 32'b0;
            end else begin
              state <= WAIT1;
            end
          end
        end
        WAIT1: begin
          if (mem_rvalid) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= ld_data;
          end
        end
        DONE: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
